// File: rtl/wb_regfile_if.sv
// Writeback/decode bus for wb_regfile: MEM/WB inputs, decode read ports, forwarding result.
// The master modport drives the pipeline side; the slave modport is the register file.
interface wb_regfile_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    logic [XLEN-1:0] ALU_result_W;
    logic [XLEN-1:0] data_memory_RD_W;
    logic [AW-1:0]   register_file_WA_W;
    logic            ctrl_register_file_WE_W;
    logic            ctrl_result_W;
    logic [AW-1:0]   register_file_RA1_D;
    logic [AW-1:0]   register_file_RA2_D;
    logic [XLEN-1:0] register_file_RD1_D;
    logic [XLEN-1:0] register_file_RD2_D;
    logic [XLEN-1:0] result_W;
    logic            clear_busy;

    modport master (
        output ALU_result_W,
        output data_memory_RD_W,
        output register_file_WA_W,
        output ctrl_register_file_WE_W,
        output ctrl_result_W,
        output register_file_RA1_D,
        output register_file_RA2_D,
        input  register_file_RD1_D,
        input  register_file_RD2_D,
        input  result_W,
        input  clear_busy
    );

    modport slave (
        input  ALU_result_W,
        input  data_memory_RD_W,
        input  register_file_WA_W,
        input  ctrl_register_file_WE_W,
        input  ctrl_result_W,
        input  register_file_RA1_D,
        input  register_file_RA2_D,
        output register_file_RD1_D,
        output register_file_RD2_D,
        output result_W,
        output clear_busy
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback result select plus 32x32 register file with a post-reset clear sweep.
// Optional macro REGFILE_BYPASS_EN: read ports see the value being written this cycle.
module wb_regfile #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input logic        clk,
    input logic        rst,
    wb_regfile_if.slave wb
);
    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] regs_q [NREG];

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] result;
    logic            wb_we;

    assign result        = wb.ctrl_result_W ? wb.data_memory_RD_W : wb.ALU_result_W;
    assign wb.result_W   = result;
    assign wb.clear_busy = (state_q == StClear);
    assign wb_we         = wb.ctrl_register_file_WE_W && (wb.register_file_WA_W != '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        wr_addr = idx_q;
        wr_data = '0;
        case (state_q)
            StClear: begin
                wr_en = 1'b1;
                if (idx_q == AW'(NREG - 1)) begin
                    state_d = StRun;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StRun: begin
                if (wb_we) begin
                    wr_en   = 1'b1;
                    wr_addr = wb.register_file_WA_W;
                    wr_data = result;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
            idx_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Storage has no reset of its own; the sweep zeroes it after rst drops.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        wb.register_file_RD1_D = '0;
        wb.register_file_RD2_D = '0;
        if (state_q == StRun) begin
            if (wb.register_file_RA1_D != '0) begin
                wb.register_file_RD1_D = regs_q[wb.register_file_RA1_D];
`ifdef REGFILE_BYPASS_EN
                if (wb_we && (wb.register_file_WA_W == wb.register_file_RA1_D)) begin
                    wb.register_file_RD1_D = result;
                end
`endif
            end
            if (wb.register_file_RA2_D != '0) begin
                wb.register_file_RD2_D = regs_q[wb.register_file_RA2_D];
`ifdef REGFILE_BYPASS_EN
                if (wb_we && (wb.register_file_WA_W == wb.register_file_RA2_D)) begin
                    wb.register_file_RD2_D = result;
                end
`endif
            end
        end
    end
endmodule
